// File: rtl/spi_master_packet_rx_if.sv
// Bus bundle between the SPI packet reader and its user / SPI slave.
// Carries the start/busy handshake, the four SPI pins and the decoded packet fields.
interface spi_master_packet_rx_if;
    logic               start;
    logic               busy;
    logic               cs_n;
    logic               sck;
    logic               sdo;
    logic               sdi;
    logic               pkt_valid;
    logic               hdr_err;
    logic               quat1_valid;
    logic               gyro1_valid;
    logic signed [15:0] quat1_w;
    logic signed [15:0] quat1_x;
    logic signed [15:0] quat1_y;
    logic signed [15:0] quat1_z;
    logic signed [15:0] gyro1_x;
    logic signed [15:0] gyro1_y;
    logic signed [15:0] gyro1_z;

    // Reader side: drives the SPI pins and publishes the packet.
    modport master (
        input  start,
        input  sdi,
        output busy,
        output cs_n,
        output sck,
        output sdo,
        output pkt_valid,
        output hdr_err,
        output quat1_valid,
        output gyro1_valid,
        output quat1_w,
        output quat1_x,
        output quat1_y,
        output quat1_z,
        output gyro1_x,
        output gyro1_y,
        output gyro1_z
    );

    // Requester / slave side: issues start, returns MISO, consumes the packet.
    modport slave (
        output start,
        output sdi,
        input  busy,
        input  cs_n,
        input  sck,
        input  sdo,
        input  pkt_valid,
        input  hdr_err,
        input  quat1_valid,
        input  gyro1_valid,
        input  quat1_w,
        input  quat1_x,
        input  quat1_y,
        input  quat1_z,
        input  gyro1_x,
        input  gyro1_y,
        input  gyro1_z
    );
endinterface

// File: rtl/spi_master_packet_rx.sv
// SPI Mode 0 master that reads one 16-byte sensor packet per start request:
// header, quaternion w/x/y/z, gyro x/y/z, flags. Bits arrive MSB first and are
// sampled at the end of each sck high phase. A good header publishes the fields
// with a pkt_valid pulse; a bad header pulses hdr_err and keeps the old fields.
module spi_master_packet_rx #(
    parameter int          CLK_DIV  = 4,
    parameter int          CS_SETUP = 4,
    parameter int          CS_HOLD  = 4,
    parameter logic [7:0]  HEADER   = 8'hAA
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_master_packet_rx_if.master  link
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

    state_t       state;
    logic [15:0]  cnt;        // cycles spent in the current SETUP/HOLD window or sck phase
    logic [6:0]   bit_cnt;    // bits already shifted in during XFER
    logic [127:0] shift_reg;
    logic         sdi_p0;
    logic         sdi_p1;

    // Big-endian 16-bit word starting at byte index 'pair' of the packet.
    function automatic logic signed [15:0] word_at(input logic [127:0] sr, input int pair);
        return $signed(16'(sr >> (112 - 8 * pair)));
    endfunction

    // Two-flop synchronizer for the asynchronous MISO pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdi_p0 <= 1'b0;
            sdi_p1 <= 1'b0;
        end else begin
            sdi_p0 <= link.sdi;
            sdi_p1 <= sdi_p0;
        end
    end

    // Transfer sequencer with registered SPI pins, handshake and packet outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            link.cs_n        <= 1'b1;
            link.sck         <= 1'b0;
            link.sdo         <= 1'b0;
            link.busy        <= 1'b0;
            link.pkt_valid   <= 1'b0;
            link.hdr_err     <= 1'b0;
            link.quat1_valid <= 1'b0;
            link.gyro1_valid <= 1'b0;
            link.quat1_w     <= '0;
            link.quat1_x     <= '0;
            link.quat1_y     <= '0;
            link.quat1_z     <= '0;
            link.gyro1_x     <= '0;
            link.gyro1_y     <= '0;
            link.gyro1_z     <= '0;
        end else begin
            // Result strobes are single-cycle; MOSI only ever carries dummy zeros.
            link.pkt_valid <= 1'b0;
            link.hdr_err   <= 1'b0;
            link.sdo       <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (link.start) begin
                        state     <= SETUP;
                        link.cs_n <= 1'b0;
                        link.busy <= 1'b1;
                    end
                end

                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                XFER: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!link.sck) begin
                            link.sck <= 1'b1;
                        end else begin
                            // End of the high phase: the slave's bit has had the whole
                            // phase to cross the synchronizer, so capture it now.
                            link.sck  <= 1'b0;
                            shift_reg <= {shift_reg[126:0], sdi_p1};
                            bit_cnt   <= bit_cnt + 7'd1;
                            if (bit_cnt == 7'd127) begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt       <= '0;
                        link.cs_n <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    link.busy <= 1'b0;
                    if (shift_reg[127:120] == HEADER) begin
                        link.quat1_w     <= word_at(shift_reg, 1);
                        link.quat1_x     <= word_at(shift_reg, 3);
                        link.quat1_y     <= word_at(shift_reg, 5);
                        link.quat1_z     <= word_at(shift_reg, 7);
                        link.gyro1_x     <= word_at(shift_reg, 9);
                        link.gyro1_y     <= word_at(shift_reg, 11);
                        link.gyro1_z     <= word_at(shift_reg, 13);
                        link.quat1_valid <= shift_reg[0];
                        link.gyro1_valid <= shift_reg[1];
                        link.pkt_valid   <= 1'b1;
                    end else begin
                        // Keep the last good packet visible; only report the error.
                        link.hdr_err <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    link.cs_n <= 1'b1;
                    link.sck  <= 1'b0;
                    link.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_packet_rx.sv
// Testbench for spi_master_packet_rx: SPI slave model, protocol monitor,
// directed vector table, hand-written corner-case sequences and random packets
// checked against a byte-level packet model.
module tb_spi_master_packet_rx;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int LATENCY  = CS_SETUP + 256 * CLK_DIV + CS_HOLD + 1;

    typedef struct packed {
        logic        good;
        logic        qv;
        logic        gv;
        logic [15:0] w, x, y, z, gx, gy, gz;
    } want_t;

    typedef struct {
        string        name;
        logic [127:0] pkt;
        want_t        want;
    } vec_t;

    logic clk;
    logic rst_n;

    spi_master_packet_rx_if link();

    spi_master_packet_rx #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .HEADER  (8'hAA)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor / slave state
    int           cyc = 0;
    logic [127:0] slave_bits = '0;
    logic [6:0]   slave_idx = '0;
    logic         prev_cs = 1'b1;
    logic         prev_sck = 1'b0;
    int           cs_fall_cyc = 0;
    int           cs_rise_cyc = -1;
    int           first_rise_cyc = -1;
    int           last_fall_cyc = 0;
    int           sck_rises = 0;
    int           cs_falls = 0;
    int           proto_err = 0;
    int           pkt_cnt = 0;
    int           hdr_cnt = 0;
    int           done_cnt = 0;
    int           pulse_cyc = 0;
    int           gap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Slave + monitor: looks at the pins 1 ns after each edge, presents the next
    // MSB-first bit after every sck fall, and records timing of every pin event.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (prev_cs && !link.cs_n) begin
                cs_fall_cyc    = cyc;
                cs_falls++;
                sck_rises      = 0;
                first_rise_cyc = -1;
                slave_idx      = 7'd127;
                if (cs_rise_cyc >= 0) gap_q.push_back(cyc - cs_rise_cyc);
            end
            if (!prev_cs && link.cs_n) cs_rise_cyc = cyc;
            if (!prev_sck && link.sck) begin
                sck_rises++;
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
            end
            if (prev_sck && !link.sck) begin
                last_fall_cyc = cyc;
                if (slave_idx != 7'd0) slave_idx = slave_idx - 7'd1;
            end
            if ((prev_sck != link.sck) && (link.cs_n || (prev_cs != link.cs_n))) proto_err++;
            if (link.pkt_valid) begin
                pkt_cnt++;
                done_cnt++;
                pulse_cyc = cyc;
            end
            if (link.hdr_err) begin
                hdr_cnt++;
                done_cnt++;
                pulse_cyc = cyc;
            end
        end
        link.sdi = link.cs_n ? 1'b0 : slave_bits[slave_idx];
        prev_cs  = link.cs_n;
        prev_sck = link.sck;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    // Packet model: bytes in order, words big-endian, flags bit0/bit1.
    function automatic want_t model(input logic [127:0] pkt, input want_t last);
        logic [7:0]   b[16];
        logic [127:0] t;
        want_t        r;
        t = pkt;
        for (int i = 0; i < 16; i++) begin
            b[i] = t[127:120];
            t    = t << 8;
        end
        if (b[0] != 8'hAA) begin
            r      = last;
            r.good = 1'b0;
            return r;
        end
        r.good = 1'b1;
        r.w    = 16'(int'(b[1])  * 256 + int'(b[2]));
        r.x    = 16'(int'(b[3])  * 256 + int'(b[4]));
        r.y    = 16'(int'(b[5])  * 256 + int'(b[6]));
        r.z    = 16'(int'(b[7])  * 256 + int'(b[8]));
        r.gx   = 16'(int'(b[9])  * 256 + int'(b[10]));
        r.gy   = 16'(int'(b[11]) * 256 + int'(b[12]));
        r.gz   = 16'(int'(b[13]) * 256 + int'(b[14]));
        r.qv   = (int'(b[15]) % 2) == 1;
        r.gv   = ((int'(b[15]) / 2) % 2) == 1;
        return r;
    endfunction

    function automatic want_t mk(input logic good, input logic qv, input logic gv,
                                 input logic [15:0] w, input logic [15:0] x,
                                 input logic [15:0] y, input logic [15:0] z,
                                 input logic [15:0] gx, input logic [15:0] gy,
                                 input logic [15:0] gz);
        want_t r;
        r.good = good; r.qv = qv; r.gv = gv;
        r.w = w; r.x = x; r.y = y; r.z = z;
        r.gx = gx; r.gy = gy; r.gz = gz;
        return r;
    endfunction

    task automatic check_fields(input string tag, input want_t e);
        check({tag, ".quat1_w"},     $unsigned(link.quat1_w), e.w);
        check({tag, ".quat1_x"},     $unsigned(link.quat1_x), e.x);
        check({tag, ".quat1_y"},     $unsigned(link.quat1_y), e.y);
        check({tag, ".quat1_z"},     $unsigned(link.quat1_z), e.z);
        check({tag, ".gyro1_x"},     $unsigned(link.gyro1_x), e.gx);
        check({tag, ".gyro1_y"},     $unsigned(link.gyro1_y), e.gy);
        check({tag, ".gyro1_z"},     $unsigned(link.gyro1_z), e.gz);
        check({tag, ".quat1_valid"}, link.quat1_valid, e.qv);
        check({tag, ".gyro1_valid"}, link.gyro1_valid, e.gv);
    endtask

    task automatic wait_done(input string tag, input int target);
        int guard = 0;
        while (done_cnt < target && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".done"}, done_cnt, target);
    endtask

    // Checks after a result pulse; call in the negedge right after the pulse starts.
    task automatic check_txn(input string tag, input want_t e, input int p0, input int h0);
        check({tag, ".latency"}, pulse_cyc - cs_fall_cyc, LATENCY);
        check({tag, ".sck_rises"}, sck_rises, 128);
        check({tag, ".cs_to_sck"}, 32'((first_rise_cyc - cs_fall_cyc) >= CS_SETUP + CLK_DIV), 1);
        check({tag, ".sck_to_cs"}, cs_rise_cyc - last_fall_cyc, CS_HOLD);
        check({tag, ".busy_low"}, link.busy, 1'b0);
        check({tag, ".protocol"}, proto_err, 0);
        check_fields(tag, e);
        @(negedge clk);
        check({tag, ".pkt_pulses"}, pkt_cnt - p0, e.good ? 1 : 0);
        check({tag, ".hdr_pulses"}, hdr_cnt - h0, e.good ? 0 : 1);
    endtask

    task automatic run_one(input string tag, input logic [127:0] pkt, input want_t e);
        int d0, p0, h0;
        slave_bits = pkt;
        d0 = done_cnt; p0 = pkt_cnt; h0 = hdr_cnt;
        @(negedge clk) link.start = 1'b1;
        @(negedge clk) link.start = 1'b0;
        wait_done(tag, d0 + 1);
        check_txn(tag, e, p0, h0);
    endtask

    task automatic wait_rises(input string tag, input int n);
        int guard = 0;
        while (sck_rises < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".reach_bit"}, 32'(sck_rises >= n), 1);
    endtask

    localparam logic [127:0] NOMINAL = 128'hAA40_0000_01FF_FE12_3400_10FF_F080_0003;

    initial begin
        vec_t         tbl[4];
        want_t        last;
        want_t        zero;
        want_t        nom;
        want_t        e;
        logic [127:0] pkt;
        int           d0, p0, h0, f0;

        rst_n      = 1'b0;
        link.start = 1'b0;
        zero = mk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        nom  = mk(1'b1, 1'b1, 1'b1, 16'h4000, 16'h0001, 16'hFFFE, 16'h1234,
                  16'h0010, 16'hFFF0, 16'h8000);

        tbl[0].name = "nominal";
        tbl[0].pkt  = NOMINAL;
        tbl[0].want = nom;
        tbl[1].name = "bad_header";
        tbl[1].pkt  = 128'h5511_2233_4455_6677_8899_AABB_CCDD_EE01;
        tbl[1].want = mk(1'b0, 1'b1, 1'b1, 16'h4000, 16'h0001, 16'hFFFE, 16'h1234,
                         16'h0010, 16'hFFF0, 16'h8000);
        tbl[2].name = "flags_fd";
        tbl[2].pkt  = 128'hAA40_0000_01FF_FE12_3400_10FF_F080_00FD;
        tbl[2].want = mk(1'b1, 1'b1, 1'b0, 16'h4000, 16'h0001, 16'hFFFE, 16'h1234,
                         16'h0010, 16'hFFF0, 16'h8000);
        tbl[3].name = "extremes";
        tbl[3].pkt  = 128'hAA7F_FF80_00FF_FF00_007F_FE80_0100_FF02;
        tbl[3].want = mk(1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000,
                         16'h7FFE, 16'h8001, 16'h00FF);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.cs_n", link.cs_n, 1'b1);
        check("reset.sck", link.sck, 1'b0);
        check("reset.sdo", link.sdo, 1'b0);
        check("reset.busy", link.busy, 1'b0);
        check("reset.pkt_valid", link.pkt_valid, 1'b0);
        check("reset.hdr_err", link.hdr_err, 1'b0);
        check_fields("reset", zero);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        last = zero;
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].name, tbl[i].pkt, tbl[i].want);
            if (tbl[i].want.good) last = tbl[i].want;
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of bit 60
        slave_bits = NOMINAL;
        p0 = pkt_cnt; h0 = hdr_cnt;
        @(negedge clk) link.start = 1'b1;
        @(negedge clk) link.start = 1'b0;
        wait_rises("midrst", 60);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.cs_n", link.cs_n, 1'b1);
        check("midrst.sck", link.sck, 1'b0);
        check("midrst.busy", link.busy, 1'b0);
        check_fields("midrst", zero);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst.no_pulse", (pkt_cnt - p0) + (hdr_cnt - h0), 0);
        check("midrst.cs_idle", link.cs_n, 1'b1);
        last = zero;
        run_one("after_rst", NOMINAL, model(NOMINAL, last));
        last = nom;
        repeat (3) @(negedge clk);

        // start pulsed again while busy
        slave_bits = tbl[3].pkt;
        d0 = done_cnt; p0 = pkt_cnt; h0 = hdr_cnt; f0 = cs_falls;
        @(negedge clk) link.start = 1'b1;
        @(negedge clk) link.start = 1'b0;
        wait_rises("busy_start", 10);
        @(negedge clk) link.start = 1'b1;
        @(negedge clk) link.start = 1'b0;
        wait_done("busy_start", d0 + 1);
        check_txn("busy_start", tbl[3].want, p0, h0);
        last = tbl[3].want;
        repeat (40) @(negedge clk);
        check("busy_start.cs_falls", cs_falls - f0, 1);
        check("busy_start.results", done_cnt - d0, 1);

        // start held high: back-to-back reads
        slave_bits = NOMINAL;
        d0 = done_cnt;
        @(negedge clk) link.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p0 = pkt_cnt; h0 = hdr_cnt;
            wait_done($sformatf("held%0d", k), d0 + k + 1);
            if (k == 2) link.start = 1'b0;
            check_txn($sformatf("held%0d", k), nom, p0, h0);
        end
        last = nom;
        check("held.gap_a", gap_q[gap_q.size() - 1], 2);
        check("held.gap_b", gap_q[gap_q.size() - 2], 2);
        repeat (40) @(negedge clk);
        check("held.stopped", done_cnt - d0, 3);

        // Random packets against the packet model
        for (int r = 0; r < 6; r++) begin
            pkt = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) != 0) pkt[127:120] = 8'hAA;
            else if (pkt[127:120] == 8'hAA) pkt[127:120] = 8'hAB;
            e = model(pkt, last);
            run_one($sformatf("rand%0d", r), pkt, e);
            if (e.good) last = e;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master_packet_rx.md
Name: spi_master_packet_rx

Overview:
- FPGA-side SPI Mode 0 master that reads the 16-byte single-sensor packet from an SPI slave: header 0xAA, quaternion w/x/y/z, gyro x/y/z, flags.
- Used as the on-FPGA loopback and bring-up reader for the MCU-facing slave, and as the receiver when one FPGA reads another's sensor link.
- On each start request it generates cs_n/sck, clocks in 128 bits MSB-first, checks the header, and publishes the decoded fields with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period. Legal range is ≥4.
- CS_SETUP, 4: clk cycles from cs_n falling to the first sck rising edge preparation (start of the first low phase).
- CS_HOLD, 4: clk cycles cs_n stays low after the final sck falling edge.
- HEADER, 8'hAA: expected value of byte 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request one packet read. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE
- cs_n  out  1  chip select, active low
- sck  out  1  SPI clock, idle low
- sdo  out  1  MOSI. Constant 0 (dummy bytes).
- sdi  in  1  MISO from slave. Asynchronous; passes through a 2-FF synchronizer.
- pkt_valid  out  1  one-cycle pulse when a packet with a good header is published
- hdr_err  out  1  one-cycle pulse when byte 0 ≠ HEADER
- quat1_valid, gyro1_valid  out  1 each  flags byte bit0, bit1
- quat1_w, quat1_x, quat1_y, quat1_z  out  16 signed  byte pairs 1-2, 3-4, 5-6, 7-8, MSB first
- gyro1_x, gyro1_y, gyro1_z  out  16 signed  byte pairs 9-10, 11-12, 13-14

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, from any state including mid-transfer, effective at that edge:
  - state IDLE
  - cs_n=1, sck=0, sdo=0, busy=0, pkt_valid=0, hdr_err=0
  - all data outputs and flags 0
  - bit counter 0, shift register 0
- FSM states: IDLE → SETUP → XFER → HOLD → DONE → IDLE.
- IDLE:
  - cs_n=1, sck=0.
  - start=1 moves to SETUP at the next edge; cs_n goes 0 and busy goes 1 on that same edge.
- SETUP:
  - Count CS_SETUP cycles with sck=0, then enter XFER.
- XFER: 128 bits, each bit is CLK_DIV cycles of sck=0 followed by CLK_DIV cycles of sck=1.
  - Sample: on the last clk cycle of each high phase, the synchronized sdi is shifted into the LSB of a 128-bit shift register (left shift).
  - Slave timing: the slave updates on sck falling edges. The sample point lies ≥CLK_DIV-2 cycles after the pin settles, which covers the 2-FF latency.
  - Exit: after the 128th high phase, sck returns to 0 and the FSM enters HOLD.
- HOLD:
  - cs_n=0, sck=0 for CS_HOLD cycles.
  - Then cs_n=1 and the FSM enters DONE on the same edge.
- DONE (1 cycle):
  - Header good (byte0 == HEADER): load all data outputs and flags from the shift register and pulse pkt_valid.
  - Header bad: pulse hdr_err and leave all data outputs unchanged (they hold the last good packet).
  - Flags bits [7:2] are ignored.
  - busy drops to 0 at the edge leaving DONE.
- Latency: start accepted at edge T. The pkt_valid/hdr_err pulse is high during the cycle after edge T + CS_SETUP + 256·CLK_DIV + CS_HOLD + 1.
- start while busy=1 is ignored (not queued).
- start held high continuously issues back-to-back reads with exactly one IDLE cycle (cs_n=1) between them. Minimum cs_n-high time is 2 cycles (DONE plus IDLE).
- sck never toggles while cs_n=1. No sck edge occurs in the same cycle as a cs_n edge.
- All outputs are registered. No combinational path from sdi to any output.

Test Plan:
- Nominal read: the slave model drives AA 40 00 00 01 FF FE 12 34 00 10 FF F0 80 00 03, CLK_DIV=4, pulse start.
  - Expect quat1_w=16'h4000, quat1_x=16'h0001, quat1_y=16'hFFFE, quat1_z=16'h1234, gyro1_x=16'h0010, gyro1_y=16'hFFF0, gyro1_z=16'h8000, quat1_valid=1, gyro1_valid=1.
  - Expect one pkt_valid pulse at exactly the latency above and exactly 128 sck rising edges.
- Bad header: first byte 0x55, rest arbitrary.
  - Expect one hdr_err pulse and no pkt_valid.
  - Outputs must still equal the previous packet's values.
- Flags decode: flags byte 0xFD, all other bytes nominal.
  - Expect quat1_valid=1, gyro1_valid=0; upper flag bits have no effect.
- Reset mid-transfer: assert rst_n=0 during bit 60 for 1 cycle.
  - On the next edge expect cs_n=1, sck=0, busy=0, and all outputs 0.
  - A subsequent start must complete a clean packet.
- start while busy: pulse start again during XFER; expect no effect and a single transaction.
- start held high: expect back-to-back packets, each cs_n-high gap exactly 2 cycles, and a pkt_valid pulse per packet.
- Timing check for both start scenarios: cs_n→first sck rise ≥ CS_SETUP+CLK_DIV cycles, and last sck fall→cs_n rise = CS_HOLD cycles.
